// File: rtl/pio_ram_bridge.sv
// pio_ram_bridge: single-port synchronous RAM behind a valid/ready command port.
// It supports read, write and block fill. A background scanner periodically reads
// successive addresses and shows the address and data on the LEDs and 7-segment digits.
module pio_ram_bridge #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned SCAN_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              scan_en,
  output logic [9:0]        leds,
  output logic [31:0]       hex0,
  output logic [15:0]       hex1
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned DivW  = $clog2(SCAN_DIV);

  typedef enum logic [2:0] {StIdle, StRdWait, StRdResp, StFill, StScanWait} state_e;

  // DE1 active-low segment patterns; bit 7 (decimal point) stays off.
  function automatic logic [7:0] seg7(input logic [3:0] n);
    seg7 = 8'hFF;
    case (n)
      4'h0: seg7 = 8'hC0;
      4'h1: seg7 = 8'hF9;
      4'h2: seg7 = 8'hA4;
      4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;
      4'h5: seg7 = 8'h92;
      4'h6: seg7 = 8'h82;
      4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;
      4'h9: seg7 = 8'h90;
      4'hA: seg7 = 8'h88;
      4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;
      4'hD: seg7 = 8'hA1;
      4'hE: seg7 = 8'h86;
      4'hF: seg7 = 8'h8E;
    endcase
  endfunction

  state_e            r_state, w_state_d;
  logic              r_started;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [DATA_W-1:0] r_mem [Depth];
  logic [DATA_W-1:0] r_ram_q;
  logic [DivW-1:0]   r_div;
  logic [ADDR_W-1:0] r_scan_addr;
  logic [ADDR_W-1:0] r_scan_rd_addr;
  logic              r_scan_pend;
  logic              r_disp_valid;
  logic [DATA_W-1:0] r_disp_data;
  logic [ADDR_W-1:0] r_disp_addr;

  logic              w_idle;
  logic              w_scan_issue;
  logic              w_hs;
  logic              w_tc;
  logic              w_fill_last;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdat;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [15:0]       w_disp16;
  logic [7:0]        w_disp8;

  // r_started keeps the port closed until the first edge after reset release.
  assign w_idle       = (r_state == StIdle) && r_started;
  // A pending scan only wins an idle cycle when no command is offered.
  assign w_scan_issue = w_idle && r_scan_pend && !cmd_valid;
  assign cmd_ready    = w_idle && !w_scan_issue;
  assign w_hs         = cmd_valid && cmd_ready;
  assign w_tc         = scan_en && (r_div == DivW'(SCAN_DIV - 1));
  assign w_fill_last  = (r_fill_cnt == {ADDR_W{1'b1}});
  assign w_rd_addr    = w_scan_issue ? r_scan_addr : cmd_addr;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

  assign w_disp16 = 16'(r_disp_data);
  assign w_disp8  = 8'(r_disp_addr);
  assign leds     = r_started ? {r_state != StIdle, scan_en, w_disp16[7:0]} : 10'h000;
  assign hex0     = r_disp_valid ? {seg7(w_disp16[15:12]), seg7(w_disp16[11:8]),
                                    seg7(w_disp16[7:4]), seg7(w_disp16[3:0])} : 32'hFFFF_FFFF;
  assign hex1     = r_disp_valid ? {seg7(w_disp8[7:4]), seg7(w_disp8[3:0])} : 16'hFFFF;

  // Next-state and RAM write-port selection.
  always_comb begin
    w_state_d = r_state;
    w_we      = 1'b0;
    w_waddr   = cmd_addr;
    w_wdat    = cmd_wdata;
    case (r_state)
      StIdle: begin
        if (w_hs) begin
          case (cmd_op)
            2'b00:   w_state_d = StRdWait;
            2'b01:   w_we = 1'b1;
            2'b10:   w_state_d = StFill;
            default: w_state_d = StIdle;
          endcase
        end else if (w_scan_issue) begin
          w_state_d = StScanWait;
        end
      end
      StRdWait:   w_state_d = StRdResp;
      StRdResp:   w_state_d = StIdle;
      StFill: begin
        w_we    = 1'b1;
        w_waddr = r_fill_cnt;
        w_wdat  = r_wdata;
        if (w_fill_last) w_state_d = StIdle;
      end
      StScanWait: w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  // Control state, responses and display registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StIdle;
      r_started      <= 1'b0;
      r_fill_cnt     <= '0;
      r_wdata        <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= '0;
      r_scan_rd_addr <= '0;
      r_disp_valid   <= 1'b0;
      r_disp_data    <= '0;
      r_disp_addr    <= '0;
    end else begin
      r_state     <= w_state_d;
      r_started   <= 1'b1;
      r_rsp_valid <= 1'b0;
      if (w_hs) begin
        r_wdata <= cmd_wdata;
        if (cmd_op == 2'b01) begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= cmd_wdata;
        end
        if (cmd_op == 2'b11) r_rsp_valid <= 1'b1;
        if (cmd_op == 2'b10) r_fill_cnt <= '0;
      end
      if (r_state == StRdWait) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= r_ram_q;
      end
      if (r_state == StFill) begin
        r_fill_cnt <= r_fill_cnt + ADDR_W'(1);
        if (w_fill_last) begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_wdata;
        end
      end
      if (w_scan_issue) r_scan_rd_addr <= r_scan_addr;
      if (r_state == StScanWait) begin
        r_disp_valid <= 1'b1;
        r_disp_data  <= r_ram_q;
        r_disp_addr  <= r_scan_rd_addr;
      end
    end
  end

  // Scan divider, scan address and the single pending-read flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div       <= '0;
      r_scan_addr <= '0;
      r_scan_pend <= 1'b0;
    end else begin
      if (!scan_en || w_tc) r_div <= '0;
      else                  r_div <= r_div + DivW'(1);
      if (w_tc) begin
        r_scan_addr <= r_scan_addr + ADDR_W'(1);
        r_scan_pend <= 1'b1;
      end else if (w_scan_issue) begin
        r_scan_pend <= 1'b0;
      end
    end
  end

  // RAM array: contents are not reset; read data is registered.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdat;
    r_ram_q <= r_mem[w_rd_addr];
  end

endmodule

// File: tb/tb_pio_ram_bridge.sv
// Directed bench for pio_ram_bridge: command table plus hand-written multi-cycle sequences.
module tb_pio_ram_bridge;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          scan_en = 1'b0;
  logic [9:0]    leds;
  logic [31:0]   hex0;
  logic [15:0]   hex1;

  pio_ram_bridge #(.DATA_W(DW), .ADDR_W(AW), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .scan_en(scan_en),
    .leds(leds), .hex0(hex0), .hex1(hex1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
    bit            chk_data;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer one command, wait for the handshake, then count cycles to rsp_valid (-1 if none).
  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd, output int lat);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    lat = -1; rd = '0;
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic [7:0]    ea;
    logic [15:0]   prev, h_before;
    int lat, low, n, hs, hs_prev, seen;
    logic [AW-1:0] bw_a [3];
    logic [DW-1:0] bw_d [3];

    vecs[0]  = '{2'b01, 6'h2A, 8'hA5, 8'hA5, 1, 1'b1};
    vecs[1]  = '{2'b00, 6'h2A, 8'h00, 8'hA5, 2, 1'b1};
    vecs[2]  = '{2'b01, 6'h00, 8'h01, 8'h01, 1, 1'b1};
    vecs[3]  = '{2'b01, 6'h3F, 8'h80, 8'h80, 1, 1'b1};
    vecs[4]  = '{2'b01, 6'h15, 8'h5A, 8'h5A, 1, 1'b1};
    vecs[5]  = '{2'b00, 6'h00, 8'h00, 8'h01, 2, 1'b1};
    vecs[6]  = '{2'b00, 6'h3F, 8'h00, 8'h80, 2, 1'b1};
    vecs[7]  = '{2'b00, 6'h15, 8'h00, 8'h5A, 2, 1'b1};
    vecs[8]  = '{2'b01, 6'h15, 8'hC3, 8'hC3, 1, 1'b1};
    vecs[9]  = '{2'b00, 6'h15, 8'h00, 8'hC3, 2, 1'b1};
    vecs[10] = '{2'b11, 6'h15, 8'h77, 8'h00, 1, 1'b0};
    vecs[11] = '{2'b00, 6'h2A, 8'h00, 8'hA5, 2, 1'b1};
    vecs[12] = '{2'b00, 6'h15, 8'h00, 8'hC3, 2, 1'b1};

    // Reset state and release.
    repeat (3) @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 0);
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset rsp_rdata", 32'(rsp_rdata), 0);
    check("reset leds", 32'(leds), 0);
    check("reset hex0", hex0, 32'hFFFF_FFFF);
    check("reset hex1", 32'(hex1), 32'h0000_FFFF);
    reset = 1'b0;
    #1 check("ready before first edge", 32'(cmd_ready), 0);
    @(negedge clk);
    check("ready after first edge", 32'(cmd_ready), 1);

    // Command table.
    foreach (vecs[i]) begin
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].chk_data) check($sformatf("vec%0d rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
    end

    // Back-to-back writes, one per cycle.
    bw_a[0] = 6'h10; bw_a[1] = 6'h11; bw_a[2] = 6'h12;
    bw_d[0] = 8'h11; bw_d[1] = 8'h22; bw_d[2] = 8'h33;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = bw_a[0]; cmd_wdata = bw_d[0];
    for (int i = 0; i < 3; i++) begin
      #1 check("b2b write ready", 32'(cmd_ready), 1);
      @(posedge clk); #1;
      if (i < 2) begin
        cmd_addr = bw_a[i+1]; cmd_wdata = bw_d[i+1];
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b write rsp_valid", 32'(rsp_valid), 1);
      check("b2b write rdata", 32'(rsp_rdata), 32'(bw_d[i]));
    end
    for (int i = 0; i < 3; i++) begin
      do_cmd(2'b00, bw_a[i], 8'h00, rd, lat);
      check("b2b readback", 32'(rd), 32'(bw_d[i]));
    end

    // Fill: ready low for DEPTH cycles, response at T+DEPTH+1.
    @(negedge clk);
    cmd_op = 2'b10; cmd_wdata = 8'h3C; cmd_valid = 1'b1;
    #1 check("fill ready", 32'(cmd_ready), 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    low = 0; lat = -1; rd = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata;
        check("fill ready at rsp", 32'(cmd_ready), 1);
        break;
      end
      if (!cmd_ready) low++;
    end
    check("fill latency", 32'(lat), DEPTH + 1);
    check("fill ready-low cycles", 32'(low), DEPTH);
    check("fill rdata", 32'(rd), 32'h3C);
    do_cmd(2'b00, 6'd0, 8'h00, rd, lat);  check("fill addr0", 32'(rd), 32'h3C);
    do_cmd(2'b00, 6'd31, 8'h00, rd, lat); check("fill addr31", 32'(rd), 32'h3C);
    do_cmd(2'b00, 6'd63, 8'h00, rd, lat); check("fill addr63", 32'(rd), 32'h3C);

    // Scanner: addresses 01..3F, wrap to 00, then 01, 02.
    @(negedge clk);
    prev = hex1;
    scan_en = 1'b1;
    ea = 8'h01;
    for (int u = 0; u < 66; u++) begin
      n = 0;
      do begin
        @(negedge clk); n++;
      end while (hex1 == prev && n < 20);
      check("scan hex1", 32'(hex1), 32'({seg(ea[7:4]), seg(ea[3:0])}));
      if (u == 0) check("scan hex0", hex0, {8'hC0, 8'hC0, 8'hB0, 8'hC6});
      prev = hex1;
      ea = (ea + 8'd1) & 8'h3F;
    end
    n = 0;
    while (leds[9] && n < 20) begin
      @(negedge clk); n++;
    end
    check("scan leds idle", 32'(leds), 32'h13C);

    // Contention: back-to-back reads across terminal counts, then the scan read.
    @(negedge clk);
    cmd_op = 2'b00; cmd_addr = 6'd0; cmd_valid = 1'b1;
    hs_prev = 0;
    for (int r = 0; r < 6; r++) begin
      n = 0;
      #1;
      while (!cmd_ready && n < 20) begin
        @(negedge clk); #1; n++;
      end
      hs = cyc;
      if (r > 0) check("b2b read spacing", 32'(hs - hs_prev), 3);
      hs_prev = hs;
      @(posedge clk); #1 cmd_addr = 6'(r * 7 + 5);
      @(negedge clk);
      check("b2b read T+1", 32'(rsp_valid), 0);
      @(negedge clk);
      check("b2b read T+2", 32'(rsp_valid), 1);
      check("b2b read data", 32'(rsp_rdata), 32'h3C);
    end
    cmd_valid = 1'b0;
    h_before = hex1;
    @(negedge clk);
    check("scan issue ready low", 32'(cmd_ready), 0);
    check("scan issue idle", 32'(leds[9]), 0);
    @(negedge clk);
    check("scan wait busy", 32'(leds[9]), 1);
    check("scan wait display held", 32'(hex1), 32'(h_before));
    @(negedge clk);
    check("scan display updated", 32'(hex1 != h_before), 1);

    // Reset mid-read: no response.
    scan_en = 1'b0;
    repeat (6) @(negedge clk);
    cmd_op = 2'b00; cmd_addr = 6'h2A; cmd_valid = 1'b1;
    n = 0;
    #1;
    while (!cmd_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      if (k == 1) begin
        check("mid-read reset ready", 32'(cmd_ready), 0);
        reset = 1'b0;
      end
    end
    check("mid-read no rsp", 32'(seen), 0);

    // Reset mid-fill over zero-preloaded memory.
    do_cmd(2'b10, 6'd0, 8'h00, rd, lat);
    check("preload fill latency", 32'(lat), DEPTH + 1);
    @(negedge clk);
    cmd_op = 2'b10; cmd_wdata = 8'hFF; cmd_valid = 1'b1;
    #1 check("fill2 ready", 32'(cmd_ready), 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    seen = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid-fill no rsp", 32'(seen), 0);
    do_cmd(2'b00, 6'd0, 8'h00, rd, lat);  check("mid-fill addr0", 32'(rd), 32'hFF);
    do_cmd(2'b00, 6'd8, 8'h00, rd, lat);  check("mid-fill addr8", 32'(rd), 32'hFF);
    do_cmd(2'b00, 6'd9, 8'h00, rd, lat);  check("mid-fill addr9", 32'(rd), 32'h00);
    do_cmd(2'b00, 6'd40, 8'h00, rd, lat); check("mid-fill addr40", 32'(rd), 32'h00);
    do_cmd(2'b00, 6'd63, 8'h00, rd, lat); check("mid-fill addr63", 32'(rd), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_ram_bridge.md
# pio_ram_bridge

Parametrised successor to the FPGA-side 64x8 RAM: a single-port synchronous RAM of configurable width and depth, fronted by a valid/ready command port driven from HPS PIOs. It supports read, write and block-fill operations. A background scanner walks the memory and drives the board LEDs and seven-segment displays with the current address and data. It sits beside the HPS system in the top level and replaces the direct addr/we/data/q wiring.

## Interface
Parameters:
- DATA_W, 8, RAM word width; legal range 1..16.
- ADDR_W, 6, RAM address width; legal range 1..8; DEPTH = 2**ADDR_W.
- SCAN_DIV, 50_000_000, clock cycles per scanner step; minimum 4.

Ports:
- clk  in  1  system clock (CLOCK_50 domain); the block's only clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  operation: 00 read, 01 write, 10 fill, 11 reserved (treated as no-op).
- cmd_addr  in  ADDR_W  target address for read and write.
- cmd_wdata  in  DATA_W  write or fill data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data or written data; held until the next response.
- scan_en  in  1  enables the display scanner.
- leds  out  10  bit 9 busy (state != IDLE), bit 8 scan_en, bits 7:0 low byte of the displayed data.
- hex0  out  32  four 8-bit segment codes for displayed data nibbles 3..0, MSB digit in [31:24].
- hex1  out  16  two segment codes for displayed address nibbles 1..0.

## Operation
- Segment code: bits [6:0] active-low segments a..g, bit 7 always 1. Blank digit = 8'hFF. Hex digits 0-F use the standard DE1 7-seg patterns.
- Display data is zero-extended to 16 bits. Display address is zero-extended to 8 bits.
- FSM states: IDLE, RD_WAIT, RD_RESP, FILL, SCAN_WAIT.
- IDLE: cmd_ready=1. On handshake, the command is captured and executed:
  - read -> RD_WAIT.
  - write -> RAM[addr] is written on the same edge; rsp_valid pulses the next cycle with rsp_rdata=wdata; the FSM stays in IDLE.
  - fill -> FILL with fill counter=0.
  - op 11 -> rsp_valid pulses, no RAM access.
- RD_WAIT -> RD_RESP -> IDLE. rsp_rdata is loaded in RD_RESP; rsp_valid is high during RD_RESP.
- FILL: writes RAM[counter]=wdata each cycle. After counter DEPTH-1 is written, the FSM goes to IDLE and rsp_valid pulses on the first IDLE cycle with rsp_rdata=wdata.
- Scanner:
  - A free-running divider counts 0..SCAN_DIV-1 while scan_en=1. It holds at 0 while scan_en=0.
  - At terminal count, scan_addr increments (DEPTH-1 wraps to 0) and scan_pend is set.
  - When scan_pend=1, the FSM is in IDLE and cmd_valid=0, a read of scan_addr is issued: IDLE -> SCAN_WAIT -> IDLE, and scan_pend clears.
  - The display registers (data, address) update on the SCAN_WAIT exit edge.
- Arbitration: cmd_valid always beats scan_pend. A pending scan is never dropped, only delayed. A second terminal count while pending advances scan_addr and keeps a single pending read.
- cmd_ready=0 in every state except IDLE. It is also 0 in the IDLE cycle where a scan read is being issued.
- RAM contents are not reset.

## Timing
- Reset values: cmd_ready 0, rsp_valid 0, rsp_rdata 0, leds 0, hex0 32'hFFFFFFFF, hex1 16'hFFFF, scan_addr 0, divider 0, scan_pend 0, state IDLE. cmd_ready rises on the first clock edge after reset deasserts.
- Read accepted in cycle T: rsp_valid=1 in cycle T+2; cmd_ready returns to 1 in cycle T+3.
- Write accepted in cycle T: rsp_valid=1 in cycle T+1; back-to-back writes are possible at one per cycle.
- Fill accepted in cycle T: RAM[k] is written at the end of cycle T+1+k. rsp_valid=1 in cycle T+DEPTH+1. cmd_ready=0 for cycles T+1..T+DEPTH.
- Scan: display registers update 2 cycles after the scan read is issued.
- Reset asserted mid-fill: the fill aborts immediately; addresses not yet written keep their old contents; no rsp_valid.
- Reset asserted mid-read: no rsp_valid.
- cmd_valid dropping without a handshake has no effect.

## Test plan
- Reset release: cmd_ready=0 during reset and 1 one edge after. hex0=32'hFFFFFFFF, hex1=16'hFFFF, leds=0.
- Write then read: write 8'hA5 to addr 6'h2A, then read 6'h2A. rsp_rdata=8'hA5 with rsp_valid exactly 2 cycles after the read handshake.
- Fill: fill 8'h3C with DEPTH=64. cmd_ready is low for 64 cycles; rsp_valid follows at T+65; reads of addrs 0, 31 and 63 each return 8'h3C.
- Scanner with SCAN_DIV=4 after fill 8'h3C:
  - hex1 shows "01", then "02", and so on, wrapping from "3F" to "00".
  - hex0 is {8'hC0,8'hC0,8'hB0,8'hC6} ("003C").
  - leds=10'h13C while idle.
- Contention: hold back-to-back reads across a scan terminal count. Every command completes with the specified latency, and the scan read executes in the first idle cycle with cmd_valid=0.
- Reset mid-fill: assert reset at cycle T+10 of a fill of 8'hFF over memory preloaded with 8'h00. Addresses 0..8 read 8'hFF, address 9 onward reads 8'h00, and no rsp_valid occurs.
